// File: rtl/reg_xyz_pkg.sv
// Shared types and constants for the XYZ register-block responder.
package reg_xyz_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RESP,
    CLR,
    LOAD
  } state_e;

  localparam logic [7:0]  ADDR_R1          = 8'h00;
  localparam logic [7:0]  ADDR_R2          = 8'h08;
  localparam logic [63:0] R1_RST_DEFAULT   = 64'h0;
  localparam logic [63:0] R2_RST_DEFAULT   = 64'h0;
  localparam int          CLR_CYC_DEFAULT  = 10;
  localparam int          LOAD_CYC_DEFAULT = 10;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reg_xyz_phase_cnt.sv
// Loadable down-counter shared by the clear and load phases; done_o marks the
// final cycle of a phase and the count parks at zero rather than wrapping.
module reg_xyz_phase_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/reg_xyz_responder.sv
// Frontdoor responder for the XYZ register block: two registers behind a
// valid/ready request/response pair, plus a two-phase (clear, load) soft reset.
module reg_xyz_responder
  import reg_xyz_pkg::*;
#(
  parameter int                DATA_W   = 64,
  parameter int                ADDR_W   = 8,
  parameter logic [DATA_W-1:0] R1_RST   = DATA_W'(R1_RST_DEFAULT),
  parameter logic [DATA_W-1:0] R2_RST   = DATA_W'(R2_RST_DEFAULT),
  parameter int                CLR_CYC  = CLR_CYC_DEFAULT,
  parameter int                LOAD_CYC = LOAD_CYC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              soft_rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic [DATA_W-1:0] r1_q,
  output logic [DATA_W-1:0] r2_q
);

  localparam int CNT_W = $clog2(max_int(CLR_CYC, LOAD_CYC) + 1);

  state_e            state_q, state_d;
  logic              pending_q, pending_d;
  logic [DATA_W-1:0] r1_d, r2_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_val;
  logic              cnt_done;
  logic              accept, hit_r1, hit_r2;
  logic              enter_clr, enter_load;

  reg_xyz_phase_cnt #(
    .CNT_W (CNT_W)
  ) u_phase_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .done_o     (cnt_done)
  );

  assign req_ready = (state_q == IDLE) && !soft_rst && !pending_q;
  assign accept    = req_valid && req_ready;
  assign hit_r1    = (req_addr == ADDR_W'(ADDR_R1));
  assign hit_r2    = (req_addr == ADDR_W'(ADDR_R2));
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q == CLR) || (state_q == LOAD);

  // NOTE: every signal written below gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    r1_d        = r1_q;
    r2_d        = r2_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    enter_clr   = 1'b0;
    enter_load  = 1'b0;
    cnt_load    = 1'b0;
    cnt_val     = '0;

    unique case (state_q)
      IDLE: begin
        if (soft_rst) begin
          enter_clr = 1'b1;
        end else if (accept) begin
          state_d     = RESP;
          rsp_err_d   = !(hit_r1 || hit_r2);
          // Reads return the pre-write value; writes and errors return 0.
          rsp_rdata_d = '0;
          if (!req_write && hit_r1) rsp_rdata_d = r1_q;
          if (!req_write && hit_r2) rsp_rdata_d = r2_q;
          if (req_write && hit_r1)  r1_d = req_wdata;
          if (req_write && hit_r2)  r2_d = req_wdata;
        end
      end
      RESP: begin
        if (soft_rst) pending_d = 1'b1;
        if (rsp_ready) begin
          if (pending_q || soft_rst) enter_clr = 1'b1;
          else                       state_d   = IDLE;
        end
      end
      CLR: begin
        if (soft_rst)      enter_clr  = 1'b1;
        else if (cnt_done) enter_load = 1'b1;
      end
      LOAD: begin
        if (soft_rst) begin
          enter_clr = 1'b1;
        end else if (cnt_done) begin
          state_d   = IDLE;
          pending_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (enter_clr) begin
      state_d  = CLR;
      r1_d     = '0;
      r2_d     = '0;
      cnt_load = 1'b1;
      cnt_val  = CNT_W'(CLR_CYC);
    end else if (enter_load) begin
      state_d  = LOAD;
      r1_d     = R1_RST;
      r2_d     = R2_RST;
      cnt_load = 1'b1;
      cnt_val  = CNT_W'(LOAD_CYC);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pending_q   <= 1'b0;
      r1_q        <= '0;
      r2_q        <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      r1_q        <= r1_d;
      r2_q        <= r2_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_reg_xyz_responder.sv
// Directed self-checking bench for reg_xyz_responder with R1_RST=R2_RST=0x42
// and 10-cycle clear/load phases.
module tb_reg_xyz_responder;

  localparam logic [63:0] RST_VAL = 64'h42;
  localparam logic [63:0] WVAL1   = 64'hDEAD_BEEF_0123_4567;
  localparam logic [63:0] WVAL2   = 64'h0000_0000_0000_1234;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        soft_rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [7:0]  req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic [63:0] r1_q;
  logic [63:0] r2_q;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  reg_xyz_responder #(
    .DATA_W   (64),
    .ADDR_W   (8),
    .R1_RST   (RST_VAL),
    .R2_RST   (RST_VAL),
    .CLR_CYC  (10),
    .LOAD_CYC (10)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .soft_rst  (soft_rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .r1_q      (r1_q),
    .r2_q      (r2_q)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  // One full transaction; rsp_ready stays low for `hold` cycles after
  // rsp_valid rises. Register values right after the accept edge are returned.
  task automatic do_req(input string tag, input logic wr, input logic [7:0] addr,
                        input logic [63:0] wdata, input int hold,
                        input logic [63:0] exp_rdata, input logic exp_err,
                        output logic [63:0] r1_acc, output logic [63:0] r2_acc);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    rsp_ready = 1'b0;
    #1 check({tag, ".ready"}, 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    r1_acc = r1_q;
    r2_acc = r2_q;
    check({tag, ".valid"}, 64'(rsp_valid), 64'd1);
    check({tag, ".rdata"}, rsp_rdata, exp_rdata);
    check({tag, ".err"}, 64'(rsp_err), 64'(exp_err));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, ".hold_valid"}, 64'(rsp_valid), 64'd1);
      check({tag, ".hold_rdata"}, rsp_rdata, exp_rdata);
      check({tag, ".hold_err"}, 64'(rsp_err), 64'(exp_err));
      check({tag, ".hold_ready"}, 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check({tag, ".valid_drop"}, 64'(rsp_valid), 64'd0);
  endtask

  // Cycles until busy falls, bounded; caller compares against the expected count.
  task automatic wait_busy_fall(output int n);
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] r1a, r2a;
    int          n;

    rst_n     = 1'b0;
    soft_rst  = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    #23;
    check("rst.valid", 64'(rsp_valid), 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.err", 64'(rsp_err), 64'd0);
    check("rst.rdata", rsp_rdata, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst.r1", r1_q, 64'd0);
    check("rst.r2", r2_q, 64'd0);
    check("rst.ready", 64'(req_ready), 64'd1);

    // Hard reset never loads R*_RST: both registers read back zero.
    do_req("rd_r1_init", 1'b0, 8'h00, '0, 0, 64'd0, 1'b0, r1a, r2a);
    do_req("rd_r2_init", 1'b0, 8'h08, '0, 0, 64'd0, 1'b0, r1a, r2a);

    do_req("wr_r1", 1'b1, 8'h00, WVAL1, 0, 64'd0, 1'b0, r1a, r2a);
    check("wr_r1.r1_at_accept", r1a, WVAL1);
    check("wr_r1.r2_unchanged", r2a, 64'd0);
    do_req("rd_r1", 1'b0, 8'h00, '0, 0, WVAL1, 1'b0, r1a, r2a);

    // Decode errors: stalled read holds err/zero data; write changes nothing.
    do_req("rd_bad", 1'b0, 8'h10, '0, 5, 64'd0, 1'b1, r1a, r2a);
    do_req("wr_bad", 1'b1, 8'h10, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'd0, 1'b1, r1a, r2a);
    check("wr_bad.r1", r1a, WVAL1);
    check("wr_bad.r2", r2a, 64'd0);

    // Soft reset from IDLE: 10 cycles cleared, 10 cycles loaded, then ready.
    @(negedge clk);
    soft_rst = 1'b1;
    @(posedge clk);
    #1;
    soft_rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check($sformatf("srst.busy[%0d]", i), 64'(busy), 64'd1);
      check($sformatf("srst.ready[%0d]", i), 64'(req_ready), 64'd0);
      check($sformatf("srst.r1[%0d]", i), r1_q, (i < 10) ? 64'd0 : RST_VAL);
      check($sformatf("srst.r2[%0d]", i), r2_q, (i < 10) ? 64'd0 : RST_VAL);
      @(posedge clk);
      #1;
    end
    check("srst.busy_end", 64'(busy), 64'd0);
    check("srst.ready_end", 64'(req_ready), 64'd1);
    do_req("rd_after_srst", 1'b0, 8'h00, '0, 0, RST_VAL, 1'b0, r1a, r2a);

    // soft_rst together with req_valid in IDLE: request must wait out the reset.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 8'h08;
    soft_rst  = 1'b1;
    #1 check("race.ready", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    soft_rst = 1'b0;
    check("race.no_rsp", 64'(rsp_valid), 64'd0);
    check("race.busy", 64'(busy), 64'd1);
    wait_busy_fall(n);
    check("race.busy_cycles", 64'(n), 64'd20);
    check("race.ready_after", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("race.valid", 64'(rsp_valid), 64'd1);
    check("race.rdata", rsp_rdata, RST_VAL);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;

    // soft_rst during a stalled response: response completes, then CLR.
    do_req("wr_r2", 1'b1, 8'h08, WVAL2, 0, 64'd0, 1'b0, r1a, r2a);
    check("wr_r2.r2_at_accept", r2a, WVAL2);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 8'h08;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    soft_rst  = 1'b1;
    @(posedge clk);
    #1;
    soft_rst = 1'b0;
    check("pend.valid", 64'(rsp_valid), 64'd1);
    check("pend.rdata", rsp_rdata, WVAL2);
    check("pend.busy", 64'(busy), 64'd0);
    check("pend.ready", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    check("pend.valid2", 64'(rsp_valid), 64'd1);
    check("pend.rdata2", rsp_rdata, WVAL2);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("pend.valid_drop", 64'(rsp_valid), 64'd0);
    check("pend.busy_clr", 64'(busy), 64'd1);
    check("pend.r2_clr", r2_q, 64'd0);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    check("pend.r1_load", r1_q, RST_VAL);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    soft_rst = 1'b1;
    @(posedge clk);
    #1;
    soft_rst = 1'b0;
    check("restart.r1", r1_q, 64'd0);
    check("restart.busy", 64'(busy), 64'd1);
    wait_busy_fall(n);
    check("restart.busy_cycles", 64'(n), 64'd20);
    do_req("rd_after_restart", 1'b0, 8'h00, '0, 0, RST_VAL, 1'b0, r1a, r2a);

    // Hard reset mid-response drops it and clears everything at once.
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 8'h00;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("hrst.valid_before", 64'(rsp_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("hrst.valid", 64'(rsp_valid), 64'd0);
    check("hrst.r1", r1_q, 64'd0);
    check("hrst.rdata", rsp_rdata, 64'd0);
    check("hrst.busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("hrst.ready", 64'(req_ready), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_xyz_responder.md
Name: reg_xyz_responder

Overview:
- Frontdoor register-bus responder for the XYZ register block: holds two 64-bit registers, r1 and r2.
- Serves read/write requests over a valid/ready request channel and a valid/ready response channel.
- Executes a two-phase soft reset: clear to zero, then load the reset values.
- Exports register contents so the bench can compare frontdoor and backdoor views.

Parameters:
- DATA_W, 64, register and data width.
- ADDR_W, 8, request byte-address width.
- R1_RST, 64'h0, value loaded into r1 in the load phase.
- R2_RST, 64'h0, value loaded into r2 in the load phase.
- CLR_CYC, 10, cycles the clear phase lasts (≥1).
- LOAD_CYC, 10, cycles the load phase lasts before requests are accepted again (≥1).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- soft_rst  in  1  soft-reset request, level-sampled each cycle.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  address decode error.
- busy  out  1  high during both soft-reset phases.
- r1_q  out  DATA_W  current r1 (observation).
- r2_q  out  DATA_W  current r2 (observation).

Behaviour:
- Address map: 0x00 = r1, 0x08 = r2. Any other address sets rsp_err=1. Erroring writes change nothing; erroring reads return 0.
- rst_n low (async): state IDLE, r1=r2=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, busy=0, pending=0, counter=0. rst_n does NOT run the load phase; registers stay 0 until a soft reset.
- req_ready = (state==IDLE) && !soft_rst && !pending. Combinational, no registered path from req_valid.
- IDLE:
  - Accept → RESP next cycle. Writes update the register on the accept edge.
  - rsp_valid rises one cycle after accept. rsp_rdata returns the value before any same-cycle write; only reads return data.
- RESP:
  - rsp_valid, rsp_rdata and rsp_err are held stable until rsp_ready.
  - On handshake, rsp_valid drops next cycle → IDLE.
  - No back-to-back acceptance: minimum two cycles per transaction.
- soft_rst handling:
  - In IDLE: → CLR next cycle, even if req_valid is high (request not accepted).
  - In RESP: latched into pending. The response completes normally, then → CLR instead of IDLE.
- CLR:
  - r1=r2=0 on entry, busy=1, counter counts CLR_CYC cycles → LOAD.
  - soft_rst asserted in CLR restarts the counter.
- LOAD:
  - r1=R1_RST, r2=R2_RST on entry, busy=1, counter counts LOAD_CYC cycles → IDLE; pending cleared.
  - soft_rst asserted in LOAD → CLR (restart sequence).
- Counter is $clog2(max(CLR_CYC,LOAD_CYC)+1) bits, reloaded on each phase entry, no wrap.
- rst_n asserted mid-operation in any state: immediate return to reset values; an in-flight response is dropped.

Decomposition:
- Shared package reg_xyz_pkg holds:
  - state enum {IDLE, RESP, CLR, LOAD};
  - ADDR_R1=8'h00, ADDR_R2=8'h08;
  - default reset-value constants.
- One sub-module, reg_xyz_phase_cnt: loadable down-counter with a done flag, used by both phases. Everything else is flat.

Test Plan:
- rst_n pulse, then read 0x00 and 0x08 → rsp_rdata=0, rsp_err=0, rsp_valid one cycle after accept.
- Write 0x00 ← 64'hDEAD_BEEF_0123_4567, then read 0x00 → r1_q updates on the accept edge; read returns the same value; r2 unchanged.
- Read 0x10 with rsp_ready held low for 5 cycles → rsp_err=1 and rsp_rdata=0, held stable all 5 cycles; write 0x10 → no register changes.
- R1_RST=R2_RST=64'h42, CLR_CYC=LOAD_CYC=10, soft_rst pulse in IDLE → busy high for 20 cycles, registers 0 for 10 cycles then 64'h42, req_ready low throughout; then read returns 64'h42.
- soft_rst asserted same cycle as req_valid in IDLE → request not accepted, no response; request accepted after busy falls.
- soft_rst during RESP with rsp_ready low 3 cycles → response delivered intact, then CLR entered; soft_rst again mid-LOAD → sequence restarts in CLR.
